depth_scan_sequencer: RTL and testbench
=======================================

# depth_scan_sequencer

Hardware raster controller for the depth map scanner. It steps the horizontal and vertical servo PWM generators through a serpentine grid and waits a settle time at each grid cell. At each cell it averages the IR sensor reading and paints the result as a grayscale block into the VGA framebuffer write port. It sits beside the MCU in the top-level wrapper, and an external write arbiter shares the framebuffer port between it and the MCU. Completion raises an interrupt pulse for the MCU.

## Interface

Parameters:
- H_STEPS, 8: horizontal grid positions (1..8); servo command = column index, 3 bits.
- V_STEPS, 8: vertical grid positions (1..8).
- SETTLE_CYCLES, 1000000: CLK cycles waited after every servo move (≥1).
- SAMPLES, 4: IR readings averaged per cell; power of two, 1..16.
- SAMPLE_GAP, 16: CLK cycles between successive readings (≥1).
- CELL, 4: pixel edge of each painted block (1..8).
- X_ORG, 0: framebuffer X of cell (0,0), 7 bits.
- Y_ORG, 0: framebuffer Y of cell (0,0), 6 bits.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- START  in  1  level; begins a scan when sampled high in IDLE.
- ABORT  in  1  level; terminates any scan.
- IRSENSOR  in  8  IR reading; larger = nearer.
- SERVO_H  out  3  horizontal position command, held.
- SERVO_V  out  3  vertical position command, held.
- SERVO_LD  out  1  one-cycle strobe; servos latch SERVO_H/SERVO_V.
- FB_REQ  out  1  framebuffer write request.
- FB_GNT  in  1  grant from arbiter (MCU has priority).
- FB_WA  out  13  write address {y[5:0], x[6:0]}.
- FB_WD  out  8  RGB332 pixel data.
- FB_WE  out  1  write enable = FB_REQ & FB_GNT (combinational).
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on normal completion; OR into the MCU interrupt.

## Operation

- States: IDLE, MOVE, SETTLE, SAMPLE, PAINT, NEXT, HOME.
- IDLE: START=1 → clear column c and row r to 0 → MOVE.
- MOVE (1 cycle): SERVO_H=c, SERVO_V=r, SERVO_LD=1 → SETTLE.
- SETTLE: count SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE:
  - Add IRSENSOR into accumulator on its 1st cycle, then every SAMPLE_GAP cycles.
  - Accumulator is 8+log2(SAMPLES) bits, cleared on entry.
  - After the SAMPLES-th add: avg = acc >> log2(SAMPLES), truncating, no saturation. Registered → PAINT.
- PAINT:
  - FB_REQ=1; FB_WD = {avg[7:5], avg[7:5], avg[7:6]}.
  - Pixel offsets (px,py) run row-major 0..CELL-1.
  - FB_WA = {Y_ORG + r*CELL + py, X_ORG + c*CELL + px}, each field truncated to its width.
  - Offsets advance only on cycles with FB_GNT=1.
  - FB_GNT=0 holds address/data unchanged.
  - After the CELL²-th granted write → NEXT with FB_REQ=0.
- NEXT (1 cycle), serpentine order:
  - Even r: c increments; at H_STEPS-1 instead r increments, c held.
  - Odd r: c decrements; at 0 instead r increments.
  - If the just-finished cell was the last (r=V_STEPS-1, c at row end) → HOME with DONE=1 this cycle.
  - Otherwise → MOVE.
- HOME (1 cycle): SERVO_H=0, SERVO_V=0, SERVO_LD=1 → IDLE.
- ABORT=1 in any non-IDLE state → HOME next cycle.
  - FB_REQ drops immediately (registered).
  - No DONE pulse.
  - ABORT has priority over every other transition.
- START while BUSY is ignored. START and ABORT both high in IDLE: stay IDLE.

## Timing

- Reset (RESET_N=0 at an edge), from any state including mid-PAINT:
  - State → IDLE; all counters and the accumulator cleared.
  - SERVO_H=0, SERVO_V=0, SERVO_LD=0, FB_REQ=0, FB_WA=0, FB_WD=0, BUSY=0, DONE=0.
  - Reset issues no servo strobe.
- All outputs are registered except FB_WE.
- START high at edge k → BUSY=1 and state MOVE at k+1 → SERVO_LD high during cycle k+1.
- Cells per scan: H_STEPS×V_STEPS.
- Cycles per cell with continuous grant: 1 + SETTLE_CYCLES + (SAMPLES-1)×SAMPLE_GAP + 1 + CELL² + 1.
- Each FB_GNT=0 cycle during PAINT adds one cycle.
- DONE is asserted in the NEXT cycle of the last cell. BUSY stays high through HOME and drops the following cycle.

## Test plan

Bench parameters unless noted: H_STEPS=2, V_STEPS=2, SETTLE_CYCLES=4, SAMPLES=4, SAMPLE_GAP=2, CELL=2, X_ORG=10, Y_ORG=5.

1. Full scan: IRSENSOR=8'hE0, FB_GNT=1.
   - 4 SERVO_LD strobes before HOME, with (H,V) = (0,0),(1,0),(1,1),(0,1).
   - 16 writes of FB_WD=8'hFF; cell (1,0) addresses y=5..6, x=12..13.
   - One DONE pulse; final strobe with (0,0); BUSY low 1 cycle after HOME.
2. Averaging: IRSENSOR samples 10,20,30,41 → avg 25 (truncated) → FB_WD=8'h00. Samples 255×4 → FB_WD=8'hFF, no overflow.
3. Grant stall: FB_GNT low for 3 cycles mid-PAINT → FB_WA/FB_WD frozen, FB_WE=0; cell finishes 3 cycles later with exactly 4 writes.
4. ABORT during SETTLE of cell 2 → HOME next cycle, SERVO_LD with (0,0), no DONE, no further FB_REQ. ABORT during PAINT → FB_REQ low next cycle.
5. RESET_N low during PAINT → next cycle all outputs 0, state IDLE, no strobe. New START afterwards runs a full clean scan.
6. START pulses while BUSY → ignored, same cycle count as scenario 1. START+ABORT together in IDLE → remains IDLE.

Source files
------------

// File: rtl/depth_scan_sequencer.sv
// Serpentine raster controller for the depth map scanner: moves the servos,
// settles, averages IR readings per cell and paints a grayscale block.
module depth_scan_sequencer #(
    parameter int H_STEPS       = 8,
    parameter int V_STEPS       = 8,
    parameter int SETTLE_CYCLES = 1000000,
    parameter int SAMPLES       = 4,
    parameter int SAMPLE_GAP    = 16,
    parameter int CELL          = 4,
    parameter int X_ORG         = 0,
    parameter int Y_ORG         = 0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        ABORT,
    input  logic [7:0]  IRSENSOR,
    output logic [2:0]  SERVO_H,
    output logic [2:0]  SERVO_V,
    output logic        SERVO_LD,
    output logic        FB_REQ,
    input  logic        FB_GNT,
    output logic [12:0] FB_WA,
    output logic [7:0]  FB_WD,
    output logic        FB_WE,
    output logic        BUSY,
    output logic        DONE,
    output logic [2:0]  DBG_STATE
);
    localparam int LOG2S = $clog2(SAMPLES);
    localparam int AW    = 8 + LOG2S;
    localparam int SW    = $clog2(SETTLE_CYCLES + 1);
    localparam int GW    = $clog2(SAMPLE_GAP + 1);
    localparam int NW    = $clog2(SAMPLES + 1);
    localparam logic [2:0] H_LAST = 3'(H_STEPS - 1);
    localparam logic [2:0] V_LAST = 3'(V_STEPS - 1);
    localparam logic [2:0] C_LAST = 3'(CELL - 1);

    typedef enum logic [2:0] {IDLE, MOVE, SETTLE, SAMPLE, PAINT, NEXT, HOME} state_t;

    state_t          state_q, state_d;
    logic [2:0]      c_q, c_d, r_q, r_d, px_q, px_d, py_q, py_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [NW-1:0]   n_q, n_d;
    logic [AW-1:0]   acc_q, acc_d, acc_sum;
    logic [2:0]      avg_hi;
    logic            last_cell;
    logic [6:0]      x_d;
    logic [5:0]      y_d;
    logic [2:0]      servo_h_q, servo_h_d, servo_v_q, servo_v_d;
    logic            servo_ld_q, servo_ld_d, fb_req_q, fb_req_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [12:0]     fb_wa_q, fb_wa_d;
    logic [7:0]      fb_wd_q, fb_wd_d;

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        r_d      = r_q;
        px_d     = px_q;
        py_d     = py_q;
        settle_d = settle_q;
        gap_d    = gap_q;
        n_d      = n_q;
        acc_d    = acc_q;
        fb_wd_d  = fb_wd_q;
        acc_sum  = acc_q + AW'(IRSENSOR);
        avg_hi   = 3'(acc_sum >> (LOG2S + 5));
        last_cell = (r_q == V_LAST) && (r_q[0] ? (c_q == 3'd0) : (c_q == H_LAST));

        case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    state_d = MOVE;
                    c_d     = 3'd0;
                    r_d     = 3'd0;
                end
            end
            MOVE: begin
                state_d  = SETTLE;
                settle_d = SW'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = SAMPLE;
                    acc_d   = '0;
                    gap_d   = '0;
                    n_d     = '0;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            SAMPLE: begin
                // The final add goes straight into the pixel colour, so PAINT starts next cycle.
                if (gap_q == '0) begin
                    acc_d = acc_sum;
                    if (n_q == NW'(SAMPLES - 1)) begin
                        state_d = PAINT;
                        fb_wd_d = {avg_hi, avg_hi, avg_hi[2:1]};
                        px_d    = 3'd0;
                        py_d    = 3'd0;
                    end else begin
                        n_d   = n_q + 1'b1;
                        gap_d = GW'(SAMPLE_GAP - 1);
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            PAINT: begin
                if (FB_GNT) begin
                    if (px_q == C_LAST) begin
                        px_d = 3'd0;
                        if (py_q == C_LAST) state_d = NEXT;
                        else                py_d = py_q + 3'd1;
                    end else begin
                        px_d = px_q + 3'd1;
                    end
                end
            end
            NEXT: begin
                if (last_cell) begin
                    state_d = HOME;
                end else begin
                    state_d = MOVE;
                    if (!r_q[0]) begin
                        if (c_q == H_LAST) r_d = r_q + 3'd1;
                        else               c_d = c_q + 3'd1;
                    end else begin
                        if (c_q == 3'd0)   r_d = r_q + 3'd1;
                        else               c_d = c_q - 3'd1;
                    end
                end
            end
            HOME:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // HOME is already the abort target, so an abort there just finishes homing.
        if (ABORT && state_q != IDLE && state_q != HOME) state_d = HOME;

        x_d = 7'(X_ORG) + 7'(c_d) * 7'(CELL) + 7'(px_d);
        y_d = 6'(Y_ORG) + 6'(r_d) * 6'(CELL) + 6'(py_d);

        servo_ld_d = (state_d == MOVE) || (state_d == HOME);
        servo_h_d  = servo_h_q;
        servo_v_d  = servo_v_q;
        if (state_d == MOVE) begin
            servo_h_d = c_d;
            servo_v_d = r_d;
        end else if (state_d == HOME) begin
            servo_h_d = 3'd0;
            servo_v_d = 3'd0;
        end
        fb_req_d = (state_d == PAINT);
        fb_wa_d  = (state_d == PAINT) ? {y_d, x_d} : fb_wa_q;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == NEXT) && last_cell;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            c_q        <= '0;
            r_q        <= '0;
            px_q       <= '0;
            py_q       <= '0;
            settle_q   <= '0;
            gap_q      <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            servo_h_q  <= '0;
            servo_v_q  <= '0;
            servo_ld_q <= 1'b0;
            fb_req_q   <= 1'b0;
            fb_wa_q    <= '0;
            fb_wd_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            r_q        <= r_d;
            px_q       <= px_d;
            py_q       <= py_d;
            settle_q   <= settle_d;
            gap_q      <= gap_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            servo_h_q  <= servo_h_d;
            servo_v_q  <= servo_v_d;
            servo_ld_q <= servo_ld_d;
            fb_req_q   <= fb_req_d;
            fb_wa_q    <= fb_wa_d;
            fb_wd_q    <= fb_wd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign SERVO_H   = servo_h_q;
    assign SERVO_V   = servo_v_q;
    assign SERVO_LD  = servo_ld_q;
    assign FB_REQ    = fb_req_q;
    assign FB_WA     = fb_wa_q;
    assign FB_WD     = fb_wd_q;
    assign FB_WE     = fb_req_q & FB_GNT;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DBG_STATE = state_q;
endmodule

// File: tb/tb_depth_scan_sequencer.sv
// Bench for depth_scan_sequencer: per-cycle stimulus plans, a cell-level
// reference model building expected output timelines, immediate assertions.
module tb_depth_scan_sequencer;
    localparam int H = 2, V = 2, ST = 4, S = 4, G = 2, C = 2, XO = 10, YO = 5;
    localparam int MAXC = 600;

    logic        CLK = 1'b0;
    logic        RESET_N, START, ABORT, FB_GNT;
    logic [7:0]  IRSENSOR;
    logic [2:0]  SERVO_H, SERVO_V, DBG_STATE;
    logic        SERVO_LD, FB_REQ, FB_WE, BUSY, DONE;
    logic [12:0] FB_WA;
    logic [7:0]  FB_WD;

    always #5 CLK = ~CLK;

    depth_scan_sequencer #(
        .H_STEPS(H), .V_STEPS(V), .SETTLE_CYCLES(ST), .SAMPLES(S),
        .SAMPLE_GAP(G), .CELL(C), .X_ORG(XO), .Y_ORG(YO)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .IRSENSOR(IRSENSOR), .SERVO_H(SERVO_H), .SERVO_V(SERVO_V),
        .SERVO_LD(SERVO_LD), .FB_REQ(FB_REQ), .FB_GNT(FB_GNT), .FB_WA(FB_WA),
        .FB_WD(FB_WD), .FB_WE(FB_WE), .BUSY(BUSY), .DONE(DONE), .DBG_STATE(DBG_STATE)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_writes;
    int end_rel;

    // stimulus plans, indexed by cycle relative to the START cycle
    bit         st_plan[MAXC], ab_plan[MAXC], rs_plan[MAXC], gn_plan[MAXC];
    logic [7:0] ir_plan[MAXC];
    // expected output timelines
    bit          e_busy[MAXC], e_ld[MAXC], e_req[MAXC], e_done[MAXC], e_zero[MAXC];
    logic [2:0]  e_h[MAXC], e_v[MAXC];
    logic [12:0] e_wa[MAXC];
    logic [7:0]  e_wd[MAXC];

    task automatic chk(input string tag, input int rel, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s rel=%0d observed=%h expected=%h", tag, rel, obs, exp);
        end
    endtask

    task automatic clear_plans();
        for (int i = 0; i < MAXC; i++) begin
            st_plan[i] = 1'b0;
            ab_plan[i] = 1'b0;
            rs_plan[i] = 1'b1;
            gn_plan[i] = 1'b1;
            ir_plan[i] = 8'($urandom_range(0, 255));
        end
        st_plan[0] = 1'b1;
    endtask

    function automatic int cell_wa(input int c, input int r, input int n);
        int px, py;
        px = n % C;
        py = n / C;
        return ((YO + r * C + py) % 64) * 128 + (XO + c * C + px) % 128;
    endfunction

    // Walks the serpentine cell list, deriving every event time from the cell timing rules.
    task automatic build_model(input int abort_at, input int reset_at);
        int t, p, home, sum, avg, wd, n, c, r;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_ld[i] = 0; e_req[i] = 0; e_done[i] = 0; e_zero[i] = 0;
            e_h[i] = '0; e_v[i] = '0; e_wa[i] = '0; e_wd[i] = '0;
        end
        t = 1;
        p = 0;
        for (int k = 0; k < H * V; k++) begin
            r = k / H;
            c = (r % 2 == 0) ? (k % H) : (H - 1 - k % H);
            e_ld[t] = 1; e_h[t] = 3'(c); e_v[t] = 3'(r);
            sum = 0;
            for (int j = 0; j < S; j++) sum += int'(ir_plan[t + 1 + ST + j * G]);
            avg = sum / S;
            wd  = (avg / 32) * 32 + (avg / 32) * 4 + avg / 64;
            p = t + 1 + ST + (S - 1) * G + 1;
            n = 0;
            while (n < C * C && p < MAXC - 8) begin
                e_req[p] = 1; e_wa[p] = 13'(cell_wa(c, r, n)); e_wd[p] = 8'(wd);
                if (gn_plan[p]) n++;
                p++;
            end
            t = p + 1;
        end
        e_done[p] = 1;
        home = p + 1;
        e_ld[home] = 1; e_h[home] = '0; e_v[home] = '0;
        for (int i = 1; i <= home; i++) e_busy[i] = 1;
        end_rel = home + 1;
        if (abort_at > 0) begin
            for (int i = abort_at + 1; i < MAXC; i++) begin
                e_busy[i] = 0; e_ld[i] = 0; e_req[i] = 0; e_done[i] = 0;
            end
            e_ld[abort_at + 1] = 1; e_busy[abort_at + 1] = 1;
            e_h[abort_at + 1] = '0; e_v[abort_at + 1] = '0;
            end_rel = abort_at + 2;
        end
        if (reset_at > 0) begin
            for (int i = reset_at + 1; i < MAXC; i++) begin
                e_busy[i] = 0; e_ld[i] = 0; e_req[i] = 0; e_done[i] = 0;
            end
            e_zero[reset_at + 1] = 1;
            e_zero[reset_at + 2] = 1;
            end_rel = reset_at + 3;
        end
        for (int i = 1; i < MAXC; i++) begin
            if (!e_ld[i]) begin
                e_h[i] = e_zero[i] ? 3'd0 : e_h[i - 1];
                e_v[i] = e_zero[i] ? 3'd0 : e_v[i - 1];
            end
        end
    endtask

    task automatic check_cycle(input int i);
        chk("busy", i, 16'(BUSY), 16'(e_busy[i]));
        chk("done", i, 16'(DONE), 16'(e_done[i]));
        chk("servo_ld", i, 16'(SERVO_LD), 16'(e_ld[i]));
        chk("servo_h", i, 16'(SERVO_H), 16'(e_h[i]));
        chk("servo_v", i, 16'(SERVO_V), 16'(e_v[i]));
        chk("fb_req", i, 16'(FB_REQ), 16'(e_req[i]));
        chk("fb_we", i, 16'(FB_WE), 16'(e_req[i] & gn_plan[i]));
        if (e_req[i]) begin
            chk("fb_wa", i, 16'(FB_WA), 16'(e_wa[i]));
            chk("fb_wd", i, 16'(FB_WD), 16'(e_wd[i]));
        end
        if (e_zero[i]) begin
            chk("rst_wa", i, 16'(FB_WA), 16'd0);
            chk("rst_wd", i, 16'(FB_WD), 16'd0);
        end
    endtask

    // Entered and left at posedge+#1; drives plan entry i, checks at the negedge.
    task automatic run_scan(input int n_cyc);
        n_writes = 0;
        for (int i = 0; i < n_cyc; i++) begin
            START = st_plan[i]; ABORT = ab_plan[i]; RESET_N = rs_plan[i];
            FB_GNT = gn_plan[i]; IRSENSOR = ir_plan[i];
            @(negedge CLK);
            if (FB_WE === 1'b1) n_writes++;
            check_cycle(i);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic full_scan_and_check(input string tag);
        build_model(0, 0);
        run_scan(end_rel + 3);
        chk(tag, end_rel, 16'(n_writes), 16'(H * V * C * C));
    endtask

    int tbl[4] = '{10, 20, 30, 41};

    initial begin
        RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0; FB_GNT = 1'b1; IRSENSOR = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("reset_busy", 0, 16'(BUSY), 16'd0);
        chk("reset_done", 0, 16'(DONE), 16'd0);
        chk("reset_ld", 0, 16'(SERVO_LD), 16'd0);
        chk("reset_h", 0, 16'(SERVO_H), 16'd0);
        chk("reset_v", 0, 16'(SERVO_V), 16'd0);
        chk("reset_req", 0, 16'(FB_REQ), 16'd0);
        chk("reset_we", 0, 16'(FB_WE), 16'd0);
        chk("reset_wa", 0, 16'(FB_WA), 16'd0);
        chk("reset_wd", 0, 16'(FB_WD), 16'd0);
        @(posedge CLK);
        #1;

        // full scan, near target, continuous grant
        clear_plans();
        for (int i = 0; i < MAXC; i++) ir_plan[i] = 8'hE0;
        full_scan_and_check("writes_full");

        // averaging with truncation: 10,20,30,41 at every cell's sample points
        clear_plans();
        for (int k = 0; k < H * V; k++)
            for (int j = 0; j < S; j++)
                ir_plan[1 + k * 17 + 1 + ST + j * G] = 8'(tbl[j]);
        full_scan_and_check("writes_avg");

        // saturating readings must not overflow
        clear_plans();
        for (int i = 0; i < MAXC; i++) ir_plan[i] = 8'hFF;
        full_scan_and_check("writes_max");

        // three-cycle grant stall in the first cell's paint
        clear_plans();
        gn_plan[14] = 0; gn_plan[15] = 0; gn_plan[16] = 0;
        full_scan_and_check("writes_stall");

        // abort during settle of the second cell
        clear_plans();
        ab_plan[20] = 1;
        build_model(20, 0);
        run_scan(end_rel + 3);
        chk("writes_abort_settle", end_rel, 16'(n_writes), 16'(C * C));

        // abort during paint
        clear_plans();
        ab_plan[14] = 1;
        build_model(14, 0);
        run_scan(end_rel + 3);

        // reset during paint, then a clean scan
        clear_plans();
        rs_plan[14] = 0; rs_plan[15] = 0;
        build_model(0, 14);
        run_scan(end_rel + 3);
        clear_plans();
        full_scan_and_check("writes_after_reset");

        // START pulses while busy, random grant and readings
        for (int rep = 0; rep < 3; rep++) begin
            clear_plans();
            for (int i = 0; i < MAXC; i++) gn_plan[i] = ($urandom_range(0, 3) != 0);
            build_model(0, 0);
            for (int i = 1; i < end_rel; i++) st_plan[i] = 1'($urandom_range(0, 1));
            run_scan(end_rel + 3);
            chk("writes_random", end_rel, 16'(n_writes), 16'(H * V * C * C));
        end

        // START and ABORT together in IDLE
        START = 1'b1; ABORT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("sa_busy", i, 16'(BUSY), 16'd0);
            chk("sa_ld", i, 16'(SERVO_LD), 16'd0);
            @(posedge CLK);
            #1;
        end
        START = 1'b0; ABORT = 1'b0;
        @(negedge CLK);
        chk("sa_idle_after", 3, 16'(BUSY), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
